// File: rtl/alu_multicycle.sv
// Registered multi-cycle ALU with a START/DONE handshake. Most operations take one cycle.
// mul, divu and remu run bit-serial engines for DATA_WIDTH cycles.
module alu_multicycle #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] OP1,
    input  logic [DATA_WIDTH-1:0] OP2,
    input  logic [OPRN_WIDTH-1:0] OPRN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] OUT,
    output logic                  ZERO,
    output logic                  ERR
);

    localparam logic [OPRN_WIDTH-1:0] OP_ADD  = OPRN_WIDTH'(8'h01);
    localparam logic [OPRN_WIDTH-1:0] OP_SUB  = OPRN_WIDTH'(8'h02);
    localparam logic [OPRN_WIDTH-1:0] OP_MUL  = OPRN_WIDTH'(8'h03);
    localparam logic [OPRN_WIDTH-1:0] OP_SRL  = OPRN_WIDTH'(8'h04);
    localparam logic [OPRN_WIDTH-1:0] OP_SLL  = OPRN_WIDTH'(8'h05);
    localparam logic [OPRN_WIDTH-1:0] OP_AND  = OPRN_WIDTH'(8'h06);
    localparam logic [OPRN_WIDTH-1:0] OP_OR   = OPRN_WIDTH'(8'h07);
    localparam logic [OPRN_WIDTH-1:0] OP_NOR  = OPRN_WIDTH'(8'h08);
    localparam logic [OPRN_WIDTH-1:0] OP_SLTU = OPRN_WIDTH'(8'h09);
    localparam logic [OPRN_WIDTH-1:0] OP_SRA  = OPRN_WIDTH'(8'h0A);
    localparam logic [OPRN_WIDTH-1:0] OP_SLT  = OPRN_WIDTH'(8'h0B);
    localparam logic [OPRN_WIDTH-1:0] OP_DIVU = OPRN_WIDTH'(8'h0C);
    localparam logic [OPRN_WIDTH-1:0] OP_REMU = OPRN_WIDTH'(8'h0D);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] a_reg;   // multiplicand, or dividend shifting into quotient
    logic [DATA_WIDTH-1:0] b_reg;   // multiplier, or divisor
    logic [DATA_WIDTH-1:0] acc;     // product accumulator, or partial remainder
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  is_rem;

    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_err;
    logic [DATA_WIDTH-1:0] acc_sum;
    logic [DATA_WIDTH:0]   trial;
    logic                  ge;
    logic [DATA_WIDTH-1:0] rem_next, quot_next, div_res;

    assign BUSY = (state != S_IDLE);
    assign DONE = (state == S_FIN);

    // Single-cycle results and the early-exit cases of divide.
    // Shifts by OP2 >= DATA_WIDTH already yield 0 or sign-fill, as required.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alu_res = '0;
        alu_err = 1'b0;
        case (OPRN)
            OP_ADD:  alu_res = OP1 + OP2;
            OP_SUB:  alu_res = OP1 - OP2;
            OP_SRL:  alu_res = OP1 >> OP2;
            OP_SLL:  alu_res = OP1 << OP2;
            OP_AND:  alu_res = OP1 & OP2;
            OP_OR:   alu_res = OP1 | OP2;
            OP_NOR:  alu_res = ~(OP1 | OP2);
            OP_SLTU: alu_res = DATA_WIDTH'(OP1 < OP2);
            OP_SRA:  alu_res = $signed(OP1) >>> OP2;
            OP_SLT:  alu_res = DATA_WIDTH'($signed(OP1) < $signed(OP2));
            OP_MUL:  alu_res = '0;
            OP_DIVU: begin
                alu_res = '1;
                alu_err = (OP2 == '0);
            end
            OP_REMU: begin
                alu_res = OP1;
                alu_err = (OP2 == '0);
            end
            default: alu_err = 1'b1;
        endcase
    end

    // One shift-add step and one restoring-divide step.
    // The trial value needs one extra bit because it can reach 2*divisor-1.
    always_comb begin
        acc_sum   = acc + (b_reg[0] ? a_reg : '0);
        trial     = {acc, a_reg[DATA_WIDTH-1]};
        ge        = (trial >= {1'b0, b_reg});
        rem_next  = ge ? DATA_WIDTH'(trial - {1'b0, b_reg}) : trial[DATA_WIDTH-1:0];
        quot_next = {a_reg[DATA_WIDTH-2:0], ge};
        div_res   = is_rem ? rem_next : quot_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (START) begin
                    if (OPRN == OP_MUL)
                        state_next = S_MUL;
                    else if ((OPRN == OP_DIVU || OPRN == OP_REMU) && OP2 != '0)
                        state_next = S_DIV;
                    else
                        state_next = S_FIN;
                end
            end
            S_MUL:   if (cnt == CNT_WIDTH'(1)) state_next = S_FIN;
            S_DIV:   if (cnt == CNT_WIDTH'(1)) state_next = S_FIN;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (RST) begin
            state  <= S_IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            cnt    <= '0;
            is_rem <= 1'b0;
            OUT    <= '0;
            ZERO   <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        a_reg  <= OP1;
                        b_reg  <= OP2;
                        acc    <= '0;
                        cnt    <= CNT_WIDTH'(DATA_WIDTH);
                        is_rem <= (OPRN == OP_REMU);
                        if (state_next == S_FIN) begin
                            OUT  <= alu_res;
                            ZERO <= (alu_res == '0);
                            ERR  <= alu_err;
                        end
                    end
                end
                S_MUL: begin
                    acc   <= acc_sum;
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt - CNT_WIDTH'(1);
                    if (cnt == CNT_WIDTH'(1)) begin
                        OUT  <= acc_sum;
                        ZERO <= (acc_sum == '0);
                        ERR  <= 1'b0;
                    end
                end
                S_DIV: begin
                    acc   <= rem_next;
                    a_reg <= quot_next;
                    cnt   <= cnt - CNT_WIDTH'(1);
                    if (cnt == CNT_WIDTH'(1)) begin
                        OUT  <= div_res;
                        ZERO <= (div_res == '0);
                        ERR  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: vector table plus random iterative ops, scored by a DONE monitor.
// Hand-written sequences cover back-to-back issue, START storms during mul and reset mid-divide.
module tb_alu_multicycle;

    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic [DW-1:0] OP1 = '0;
    logic [DW-1:0] OP2 = '0;
    logic [5:0]    OPRN = '0;
    logic          BUSY, DONE, ZERO, ERR;
    logic [DW-1:0] OUT;

    alu_multicycle #(.DATA_WIDTH(DW), .OPRN_WIDTH(6)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP1(OP1), .OP2(OP2), .OPRN(OPRN),
        .BUSY(BUSY), .DONE(DONE), .OUT(OUT), .ZERO(ZERO), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] out;
        logic          err;
        logic          zero;
        int            cyc;
    } exp_t;

    typedef struct {
        logic [5:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] out;
        logic          err;
    } vec_t;

    exp_t sb[$];
    int   tests = 0;
    int   failed = 0;
    int   done_count = 0;
    int   last_start = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every DONE must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            exp_t e;
            done_count++;
            if (sb.size() == 0) begin
                check("unexpected_done", DONE, 1'b0);
            end else begin
                e = sb.pop_front();
                check("out", OUT, e.out);
                check("err", ERR, e.err);
                check("zero", ZERO, e.zero);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_not_busy();
        int n = 0;
        while (BUSY !== 1'b0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) check("busy_timeout", BUSY, 1'b0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || BUSY !== 1'b0) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) check("drain_timeout", {BUSY, sb.size() != 0}, 2'b00);
    endtask

    // Drive one request for a single cycle, then scramble the inputs.
    task automatic issue(input logic [5:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] exp_out, input logic exp_err, input bit expect_done);
        exp_t e;
        int   lat;
        wait_not_busy();
        OPRN  = op;
        OP1   = a;
        OP2   = b;
        START = 1'b1;
        lat = (op == 6'h03 || ((op == 6'h0C || op == 6'h0D) && b != 0)) ? DW + 1 : 1;
        last_start = cyc;
        if (expect_done) begin
            e.out  = exp_out;
            e.err  = exp_err;
            e.zero = (exp_out == '0);
            e.cyc  = cyc + lat;
            sb.push_back(e);
        end
        @(negedge CLK);
        START = 1'b0;
        OP1   = $urandom;
        OP2   = $urandom;
        OPRN  = 6'($urandom);
    endtask

    vec_t vecs[$];

    initial begin
        logic [DW-1:0] a, b;
        int prev_start, done_before;

        vecs.push_back('{6'h01, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0});
        vecs.push_back('{6'h02, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{6'h04, 32'h8000_0000, 32'd40,        32'h0000_0000, 1'b0});
        vecs.push_back('{6'h04, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0});
        vecs.push_back('{6'h05, 32'h0000_0001, 32'd31,        32'h8000_0000, 1'b0});
        vecs.push_back('{6'h05, 32'h0000_0001, 32'd32,        32'h0000_0000, 1'b0});
        vecs.push_back('{6'h0A, 32'h8000_0000, 32'd40,        32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{6'h0A, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0});
        vecs.push_back('{6'h0A, 32'h7000_0000, 32'd40,        32'h0000_0000, 1'b0});
        vecs.push_back('{6'h06, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0});
        vecs.push_back('{6'h07, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11, 1'b0});
        vecs.push_back('{6'h08, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{6'h0B, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0});
        vecs.push_back('{6'h09, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0});
        vecs.push_back('{6'h03, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 1'b0});
        vecs.push_back('{6'h03, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
        vecs.push_back('{6'h03, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{6'h0C, 32'd100,       32'd7,         32'd14,        1'b0});
        vecs.push_back('{6'h0D, 32'd100,       32'd7,         32'd2,         1'b0});
        vecs.push_back('{6'h0C, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 1'b0});
        vecs.push_back('{6'h0D, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0});
        vecs.push_back('{6'h0C, 32'd3,         32'd9,         32'd0,         1'b0});
        vecs.push_back('{6'h0C, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{6'h0D, 32'd5,         32'd0,         32'd5,         1'b1});
        vecs.push_back('{6'h00, 32'd1,         32'd2,         32'd0,         1'b1});
        vecs.push_back('{6'h0E, 32'd1,         32'd2,         32'd0,         1'b1});
        vecs.push_back('{6'h3F, 32'd1,         32'd2,         32'd0,         1'b1});

        // Reset, with START held high during reset to show it is ignored.
        START = 1'b1;
        OPRN  = 6'h01;
        repeat (3) @(negedge CLK);
        RST   = 1'b0;
        START = 1'b0;
        check("reset_out",  OUT,  '0);
        check("reset_zero", ZERO, 1'b0);
        check("reset_err",  ERR,  1'b0);
        check("reset_busy", BUSY, 1'b0);
        check("reset_done", DONE, 1'b0);
        @(negedge CLK);
        check("reset_start_ignored", BUSY, 1'b0);

        // First add: DONE one cycle after START, BUSY falls right after.
        issue(6'h01, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1);
        check("add_done_cycle", DONE, 1'b1);
        check("add_busy_in_fin", BUSY, 1'b1);
        @(negedge CLK);
        check("add_busy_falls", BUSY, 1'b0);
        check("add_done_single", DONE, 1'b0);
        check("out_held", OUT, 32'h0);
        wait_drain();

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].err, 1'b1);
            wait_drain();
        end

        // Random iterative ops against a behavioural model.
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == '0) b = 32'd1;
            issue(6'h03, a, b, a * b, 1'b0, 1'b1);
            issue(6'h0C, a, b, a / b, 1'b0, 1'b1);
            issue(6'h0D, a, b, a % b, 1'b0, 1'b1);
        end
        wait_drain();

        // Back-to-back single-cycle ops: one accepted every 2 clocks.
        prev_start = 0;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            issue(6'h01, a, b, a + b, 1'b0, 1'b1);
            if (i > 0) check("b2b_spacing", last_start - prev_start, 2);
            prev_start = last_start;
        end
        wait_drain();

        // START pulsed every cycle during a mul: only the first is executed.
        done_before = done_count;
        issue(6'h03, 32'd6, 32'd7, 32'd42, 1'b0, 1'b1);
        for (int n = 0; n < DW + 4; n++) begin
            if (DONE === 1'b1) break;
            START = 1'b1;
            OPRN  = 6'h01;
            OP1   = $urandom;
            OP2   = $urandom;
            @(negedge CLK);
        end
        START = 1'b0;
        repeat (6) @(negedge CLK);
        check("storm_done_count", done_count - done_before, 1);
        check("storm_sb_empty", sb.size(), 0);

        // Reset at iteration 10 of a divu after an invalid op left ZERO=1, ERR=1.
        issue(6'h3F, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1);
        wait_drain();
        done_before = done_count;
        issue(6'h0C, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
        repeat (9) @(negedge CLK);
        RST   = 1'b1;
        START = 1'b1;
        OPRN  = 6'h0C;
        @(negedge CLK);
        RST   = 1'b0;
        START = 1'b0;
        check("abort_out",  OUT,  '0);
        check("abort_zero", ZERO, 1'b0);
        check("abort_err",  ERR,  1'b0);
        check("abort_busy", BUSY, 1'b0);
        check("abort_done", DONE, 1'b0);
        repeat (DW + 5) @(negedge CLK);
        check("abort_no_done", done_count - done_before, 0);

        issue(6'h3F, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
